// File: rtl/sopc_dbus_bridge.sv
// Data-bus bridge from the mips32_core data port to NUM_SLV address-decoded slaves.
// Req/ack handshake with wait states, core stall, timeout abort and a sticky error interrupt.
module sopc_dbus_bridge #(
   parameter int NUM_SLV = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEC_MSB = 31,
   parameter int DEC_LSB = 28,
   parameter int TIMEOUT = 16,
   localparam int SEL_W  = DATA_W / 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      m_ce_i,
   input  logic                      m_we_i,
   input  logic [ADDR_W-1:0]         m_addr_i,
   input  logic [DATA_W-1:0]         m_wdata_i,
   input  logic [SEL_W-1:0]          m_sel_i,
   output logic [DATA_W-1:0]         m_rdata_o,
   output logic                      m_stall_o,
   output logic                      m_err_o,
   output logic [NUM_SLV-1:0]        s_ce_o,
   output logic                      s_we_o,
   output logic [ADDR_W-1:0]         s_addr_o,
   output logic [DATA_W-1:0]         s_wdata_o,
   output logic [SEL_W-1:0]          s_sel_o,
   input  logic [NUM_SLV*DATA_W-1:0] s_rdata_i,
   input  logic [NUM_SLV-1:0]        s_ack_i,
   input  logic                      err_clr_i,
   output logic                      bus_err_int_o
);

   localparam int IDX_W = DEC_MSB - DEC_LSB + 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [NUM_SLV-1:0] ONE = 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx_q;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic [IDX_W-1:0] dec_idx;
   logic             mapped;
   logic             ack_hit;
   logic             tmo;

   assign dec_idx = m_addr_i[DEC_MSB:DEC_LSB];
   assign mapped  = ({{(32-IDX_W){1'b0}}, dec_idx} < NUM_SLV);
   // s_ce_o is one-hot on the latched slave, so masking ignores acks from other slaves
   assign ack_hit = |(s_ce_o & s_ack_i);
   assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
   assign tmo     = (TIMEOUT > 0) && (cnt_inc == CNT_W'(TIMEOUT));

   // stall is combinational in IDLE so the core freezes in the request cycle; gated by reset
   assign m_stall_o = rst && ((state == IDLE && m_ce_i) || state == BUSY);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         idx_q         <= '0;
         cnt           <= '0;
         m_rdata_o     <= '0;
         m_err_o       <= 1'b0;
         s_ce_o        <= '0;
         s_we_o        <= 1'b0;
         s_addr_o      <= '0;
         s_wdata_o     <= '0;
         s_sel_o       <= '0;
         bus_err_int_o <= 1'b0;
      end else begin
         case (state)
            IDLE: if (m_ce_i) begin
               s_we_o    <= m_we_i;
               s_addr_o  <= m_addr_i;
               s_wdata_o <= m_wdata_i;
               s_sel_o   <= m_sel_i;
               idx_q     <= dec_idx;
               cnt       <= '0;
               if (mapped) begin
                  s_ce_o <= ONE << dec_idx;
                  state  <= BUSY;
               end else begin
                  m_err_o   <= 1'b1;
                  m_rdata_o <= '0;
                  state     <= ERR;
               end
            end
            BUSY: begin
               cnt <= cnt_inc;
               if (ack_hit) begin
                  m_rdata_o <= s_we_o ? '0 : s_rdata_i[idx_q*DATA_W +: DATA_W];
                  s_ce_o    <= '0;
                  state     <= DONE;
               end else if (tmo) begin
                  m_err_o   <= 1'b1;
                  m_rdata_o <= '0;
                  s_ce_o    <= '0;
                  state     <= ERR;
               end
            end
            DONE: state <= IDLE;
            ERR: begin
               m_err_o <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase

         // set in ERR takes priority over a simultaneous clear
         if (state == ERR)
            bus_err_int_o <= 1'b1;
         else if (err_clr_i)
            bus_err_int_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sopc_dbus_bridge.sv
// Directed bench for sopc_dbus_bridge: decode, wait states, timeout, sticky error, reset abort.
module tb_sopc_dbus_bridge;

   logic         clk = 1'b0;
   logic         rst;
   logic         m_ce_i, m_we_i;
   logic [31:0]  m_addr_i, m_wdata_i;
   logic [3:0]   m_sel_i;
   logic [31:0]  m_rdata_o;
   logic         m_stall_o, m_err_o;
   logic [3:0]   s_ce_o;
   logic         s_we_o;
   logic [31:0]  s_addr_o, s_wdata_o;
   logic [3:0]   s_sel_o;
   logic [127:0] s_rdata_i;
   logic [3:0]   s_ack_i;
   logic         err_clr_i;
   logic         bus_err_int_o;

   int n_run = 0;
   int n_fail = 0;

   // results of the last run_access
   int          r_stall, r_ce_cyc;
   logic [3:0]  r_ce_seen, r_sel;
   logic        r_done, r_err, r_we, r_hang;
   logic [31:0] r_rdata, r_addr;

   sopc_dbus_bridge #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32), .DEC_MSB(31), .DEC_LSB(28), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .m_ce_i(m_ce_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_sel_i(m_sel_i),
      .m_rdata_o(m_rdata_o), .m_stall_o(m_stall_o), .m_err_o(m_err_o),
      .s_ce_o(s_ce_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o),
      .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
      .err_clr_i(err_clr_i), .bus_err_int_o(bus_err_int_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Core + slave model for one access; ack_at = BUSY cycle number that acks (0 = never).
   // Starts and ends shortly after a rising edge, ends in the cycle after DONE/ERR.
   task automatic run_access(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                             input logic [3:0] sel, input int ack_at, input int ack_bit, input logic [31:0] rd);
      r_stall = 0; r_ce_cyc = 0; r_ce_seen = '0; r_sel = '0; r_we = 1'b0; r_addr = '0;
      r_done = 1'b0; r_err = 1'b0; r_rdata = '0; r_hang = 1'b1;
      m_ce_i = 1'b1; m_we_i = we; m_addr_i = addr; m_wdata_i = wdata; m_sel_i = sel;
      for (int k = 0; k < 4; k++) s_rdata_i[k*32 +: 32] = (k == ack_bit) ? rd : (32'h0BAD_0000 | k);
      for (int c = 0; c < 64; c++) begin
         #1;
         if (m_stall_o) r_stall++;
         if (s_ce_o != 4'b0) begin
            r_ce_cyc++; r_ce_seen |= s_ce_o; r_we = s_we_o; r_sel = s_sel_o; r_addr = s_addr_o;
         end
         if (!m_stall_o) begin
            r_hang = 1'b0; r_err = m_err_o; r_done = !m_err_o; r_rdata = m_rdata_o;
            break;
         end
         s_ack_i = (s_ce_o != 4'b0 && r_ce_cyc == ack_at) ? (4'b0001 << ack_bit) : 4'b0000;
         @(posedge clk); #1;
      end
      m_ce_i = 1'b0; s_ack_i = 4'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; m_ce_i = 1'b0; m_we_i = 1'b0; m_addr_i = '0; m_wdata_i = '0; m_sel_i = '0;
      s_rdata_i = '0; s_ack_i = '0; err_clr_i = 1'b0;
      #3;
      n_run++;
      if ({m_rdata_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o, bus_err_int_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got rdata=%h stall=%b err=%b ce=%b addr=%h int=%b, want all zero",
                  m_rdata_o, m_stall_o, m_err_o, s_ce_o, s_addr_o, bus_err_int_o);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_read_zero_wait;
      run_access(32'h0000_0010, 1'b0, 32'h0, 4'hF, 1, 0, 32'hDEAD_BEEF);
      n_run++;
      if (r_hang || !r_done || r_rdata !== 32'hDEAD_BEEF) begin
         n_fail++; $display("FAIL read0_rdata: got done=%b hang=%b rdata=%h, want done rdata=deadbeef", r_done, r_hang, r_rdata);
      end
      n_run++;
      if (r_stall != 2 || r_ce_seen !== 4'b0001 || r_ce_cyc != 1) begin
         n_fail++; $display("FAIL read0_timing: got stall=%0d ce=%b ce_cycles=%0d, want 2 0001 1", r_stall, r_ce_seen, r_ce_cyc);
      end
   endtask

   task automatic test_write_wait;
      run_access(32'h2000_0004, 1'b1, 32'hCAFE_F00D, 4'b0011, 4, 2, 32'h7777_7777);
      n_run++;
      if (r_hang || !r_done || r_stall != 5 || r_ce_cyc != 4 || r_ce_seen !== 4'b0100) begin
         n_fail++; $display("FAIL write_timing: got done=%b stall=%0d ce_cycles=%0d ce=%b, want 1 5 4 0100", r_done, r_stall, r_ce_cyc, r_ce_seen);
      end
      n_run++;
      if (r_we !== 1'b1 || r_sel !== 4'b0011 || r_addr !== 32'h2000_0004 || s_wdata_o !== 32'hCAFE_F00D) begin
         n_fail++; $display("FAIL write_regs: got we=%b sel=%b addr=%h wdata=%h, want 1 0011 20000004 cafef00d", r_we, r_sel, r_addr, s_wdata_o);
      end
      n_run++;
      if (r_rdata !== 32'h0) begin
         n_fail++; $display("FAIL write_rdata: got %h want 0", r_rdata);
      end
   endtask

   task automatic test_unmapped;
      run_access(32'h5000_0000, 1'b0, 32'h0, 4'hF, 1, 0, 32'h1234_5678);
      n_run++;
      if (r_hang || !r_err || r_stall != 1 || r_ce_cyc != 0 || r_rdata !== 32'h0) begin
         n_fail++; $display("FAIL unmapped_err: got err=%b stall=%0d ce_cycles=%0d rdata=%h, want 1 1 0 0", r_err, r_stall, r_ce_cyc, r_rdata);
      end
      n_run++;
      if (bus_err_int_o !== 1'b1 || m_err_o !== 1'b0) begin
         n_fail++; $display("FAIL unmapped_int: got int=%b err=%b, want int=1 err=0", bus_err_int_o, m_err_o);
      end
      @(posedge clk); #1;
      n_run++;
      if (bus_err_int_o !== 1'b1) begin
         n_fail++; $display("FAIL sticky_hold: got %b want 1", bus_err_int_o);
      end
      err_clr_i = 1'b1;
      @(posedge clk); #1;
      err_clr_i = 1'b0;
      n_run++;
      if (bus_err_int_o !== 1'b0) begin
         n_fail++; $display("FAIL sticky_clear: got %b want 0", bus_err_int_o);
      end
   endtask

   task automatic test_timeout;
      run_access(32'h1000_0000, 1'b0, 32'h0, 4'hF, 0, 1, 32'h0);
      n_run++;
      if (r_hang || !r_err || r_ce_cyc != 16 || r_stall != 17 || r_rdata !== 32'h0) begin
         n_fail++; $display("FAIL timeout_abort: got err=%b ce_cycles=%0d stall=%0d rdata=%h, want 1 16 17 0", r_err, r_ce_cyc, r_stall, r_rdata);
      end
      err_clr_i = 1'b1;
      @(posedge clk); #1;
      err_clr_i = 1'b0;
      run_access(32'h1000_0000, 1'b0, 32'h0, 4'hF, 16, 1, 32'hA5A5_0016);
      n_run++;
      if (r_hang || !r_done || r_err || r_ce_cyc != 16 || r_rdata !== 32'hA5A5_0016) begin
         n_fail++; $display("FAIL ack_at_limit: got done=%b err=%b ce_cycles=%0d rdata=%h, want 1 0 16 a5a50016", r_done, r_err, r_ce_cyc, r_rdata);
      end
      n_run++;
      if (bus_err_int_o !== 1'b0) begin
         n_fail++; $display("FAIL ack_at_limit_int: got %b want 0", bus_err_int_o);
      end
   endtask

   task automatic test_ignore_ack;
      m_ce_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h1000_0008; m_sel_i = 4'hF;
      s_rdata_i = {32'h3333_3333, 32'h2222_2222, 32'h5555_AAAA, 32'h0000_1111};
      @(posedge clk); #1;
      s_ack_i = 4'b1000;
      m_addr_i = 32'h3000_0000;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_run++;
         if (m_stall_o !== 1'b1 || s_ce_o !== 4'b0010 || s_addr_o !== 32'h1000_0008) begin
            n_fail++; $display("FAIL ignore_ack_%0d: got stall=%b ce=%b addr=%h, want 1 0010 10000008", i, m_stall_o, s_ce_o, s_addr_o);
         end
      end
      s_ack_i = 4'b0010;
      @(posedge clk); #1;
      s_ack_i = 4'b0; m_ce_i = 1'b0;
      n_run++;
      if (m_stall_o !== 1'b0 || m_rdata_o !== 32'h5555_AAAA) begin
         n_fail++; $display("FAIL ignore_ack_done: got stall=%b rdata=%h, want 0 5555aaaa", m_stall_o, m_rdata_o);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_sticky_set_wins;
      m_ce_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h7000_0000;
      @(posedge clk); #1;
      m_ce_i = 1'b0;
      n_run++;
      if (m_err_o !== 1'b1 || s_ce_o !== 4'b0) begin
         n_fail++; $display("FAIL err_pulse: got err=%b ce=%b, want 1 0000", m_err_o, s_ce_o);
      end
      err_clr_i = 1'b1;
      @(posedge clk); #1;
      n_run++;
      if (bus_err_int_o !== 1'b1) begin
         n_fail++; $display("FAIL set_wins: got %b want 1", bus_err_int_o);
      end
      @(posedge clk); #1;
      err_clr_i = 1'b0;
      n_run++;
      if (bus_err_int_o !== 1'b0) begin
         n_fail++; $display("FAIL clear_after: got %b want 0", bus_err_int_o);
      end
   endtask

   task automatic test_back_to_back;
      m_ce_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h0000_0020; m_sel_i = 4'hF;
      s_rdata_i = {32'h0, 32'h0, 32'h0, 32'h1234_5678};
      @(posedge clk); #1;
      s_ack_i = 4'b0001;
      @(posedge clk); #1;
      s_ack_i = 4'b0;
      n_run++;
      if (m_stall_o !== 1'b0 || m_rdata_o !== 32'h1234_5678) begin
         n_fail++; $display("FAIL b2b_done: got stall=%b rdata=%h, want 0 12345678", m_stall_o, m_rdata_o);
      end
      @(posedge clk); #1;
      n_run++;
      if (m_stall_o !== 1'b1 || s_ce_o !== 4'b0) begin
         n_fail++; $display("FAIL b2b_idle_retake: got stall=%b ce=%b, want 1 0000", m_stall_o, s_ce_o);
      end
      @(posedge clk); #1;
      n_run++;
      if (s_ce_o !== 4'b0001) begin
         n_fail++; $display("FAIL b2b_busy: got ce=%b want 0001", s_ce_o);
      end
      s_ack_i = 4'b0001;
      @(posedge clk); #1;
      s_ack_i = 4'b0; m_ce_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_busy;
      m_ce_i = 1'b1; m_we_i = 1'b1; m_addr_i = 32'h1000_0040; m_wdata_i = 32'hFEED_0001; m_sel_i = 4'hF;
      @(posedge clk); #1;
      n_run++;
      if (s_ce_o !== 4'b0010) begin
         n_fail++; $display("FAIL rst_pre_busy: got ce=%b want 0010", s_ce_o);
      end
      #1 rst = 1'b0;
      #1;
      n_run++;
      if ({m_rdata_o, m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o, bus_err_int_o} !== '0) begin
         n_fail++; $display("FAIL rst_mid_busy: got stall=%b err=%b ce=%b we=%b addr=%h, want all zero",
                            m_stall_o, m_err_o, s_ce_o, s_we_o, s_addr_o);
      end
      m_ce_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_run++;
      if (m_err_o !== 1'b0 || m_stall_o !== 1'b0) begin
         n_fail++; $display("FAIL rst_no_err: got err=%b stall=%b, want 0 0", m_err_o, m_stall_o);
      end
      run_access(32'h1000_0044, 1'b0, 32'h0, 4'hF, 2, 1, 32'h0BEE_F00D);
      n_run++;
      if (r_hang || !r_done || r_rdata !== 32'h0BEE_F00D || r_stall != 3) begin
         n_fail++; $display("FAIL rst_recover: got done=%b rdata=%h stall=%0d, want 1 0beef00d 3", r_done, r_rdata, r_stall);
      end
   endtask

   initial begin
      test_reset;
      test_read_zero_wait;
      test_write_wait;
      test_unmapped;
      test_timeout;
      test_ignore_ack;
      test_sticky_set_wins;
      test_back_to_back;
      test_reset_mid_busy;
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
